// File: rtl/sdram_cmd_arbiter.sv
// Two-port command arbiter in front of a single-command SDRAM controller.
// Latency: request seen in IDLE at cycle n drives cmd_enable from n+1; read data returns registered one cycle after data_out_ready.
// Backpressure: the command is held on the controller port until cmd_ready; only one command is outstanding at a time.
//
// Ports:
//   clk, rst                      - single clock, synchronous active-high reset
//   reqN_valid/wr/addr/data       - requester N command (0 = sample writer, 1 = readback/dump)
//   reqN_ready                    - one-cycle pulse when the controller accepts requester N's command
//   rspN_valid, rsp_data          - one-cycle read-return pulse for port N; rsp_data shared by both ports
//   cmd_ready, cmd_enable, cmd_wr, cmd_address, cmd_data_in - controller command port
//   data_out, data_out_ready      - controller read return
//   busy                          - FSM not in IDLE
//   rd_timeout_err                - sticky flag: a read returned no data within RD_TIMEOUT cycles
//
// Build option: define SDRAM_ARB_WR_PRIO_EN to give port 0 fixed priority on
// simultaneous requests; otherwise the two ports are served round-robin.
module sdram_cmd_arbiter #(
  parameter int ADDR_W     = 23,
  parameter int DATA_W     = 32,
  parameter int RD_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_wr,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_wr,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              cmd_ready,
  output logic              cmd_enable,
  output logic              cmd_wr,
  output logic [ADDR_W-1:0] cmd_address,
  output logic [DATA_W-1:0] cmd_data_in,
  input  logic [DATA_W-1:0] data_out,
  input  logic              data_out_ready,
  output logic              busy,
  output logic              rd_timeout_err
);

  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;   // port that owns the outstanding command
  logic                last_q, last_d;     // port granted most recently
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cmd_wr_d;
  logic [ADDR_W-1:0]   cmd_address_d;
  logic [DATA_W-1:0]   cmd_data_in_d;
  logic [DATA_W-1:0]   rsp_data_d;
  logic                rsp0_valid_d, rsp1_valid_d;
  logic                rd_timeout_err_d;
  logic                grant;              // winning port when anyone is requesting

`ifdef SDRAM_ARB_WR_PRIO_EN
  assign grant = req0_valid ? 1'b0 : 1'b1;
`else
  // On a tie, serve the port that did not win last time.
  assign grant = (req0_valid && req1_valid) ? ~last_q : req1_valid;
`endif

  assign cmd_enable = (state_q == ISSUE);
  assign busy       = (state_q != IDLE);
  assign req0_ready = cmd_enable && cmd_ready && !owner_q;
  assign req1_ready = cmd_enable && cmd_ready &&  owner_q;

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    last_d           = last_q;
    cnt_d            = cnt_q;
    cmd_wr_d         = cmd_wr;
    cmd_address_d    = cmd_address;
    cmd_data_in_d    = cmd_data_in;
    rsp_data_d       = rsp_data;
    rsp0_valid_d     = 1'b0;
    rsp1_valid_d     = 1'b0;
    rd_timeout_err_d = rd_timeout_err;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          owner_d       = grant;
          last_d        = grant;
          cmd_wr_d      = grant ? req1_wr   : req0_wr;
          cmd_address_d = grant ? req1_addr : req0_addr;
          cmd_data_in_d = grant ? req1_data : req0_data;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          cnt_d   = '0;
          state_d = cmd_wr ? IDLE : WAIT_RD;
        end
      end
      WAIT_RD: begin
        // Data arriving on the terminal-count cycle takes precedence over the timeout.
        if (data_out_ready) begin
          rsp_data_d   = data_out;
          rsp0_valid_d = !owner_q;
          rsp1_valid_d =  owner_q;
          state_d      = IDLE;
        end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
          rsp_data_d       = '0;
          rsp0_valid_d     = !owner_q;
          rsp1_valid_d     =  owner_q;
          rd_timeout_err_d = 1'b1;
          state_d          = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      owner_q        <= 1'b0;
      last_q         <= 1'b1;   // port 0 preferred on the first tie
      cnt_q          <= '0;
      cmd_wr         <= 1'b0;
      cmd_address    <= '0;
      cmd_data_in    <= '0;
      rsp_data       <= '0;
      rsp0_valid     <= 1'b0;
      rsp1_valid     <= 1'b0;
      rd_timeout_err <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_q         <= last_d;
      cnt_q          <= cnt_d;
      cmd_wr         <= cmd_wr_d;
      cmd_address    <= cmd_address_d;
      cmd_data_in    <= cmd_data_in_d;
      rsp_data       <= rsp_data_d;
      rsp0_valid     <= rsp0_valid_d;
      rsp1_valid     <= rsp1_valid_d;
      rd_timeout_err <= rd_timeout_err_d;
    end
  end

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Directed bench for sdram_cmd_arbiter (RD_TIMEOUT = 8).
module tb_sdram_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 0, req0_wr = 0, req1_valid = 0, req1_wr = 0;
  logic [22:0] req0_addr = '0, req1_addr = '0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] rsp_data;
  logic        cmd_ready = 0;
  logic        cmd_enable, cmd_wr;
  logic [22:0] cmd_address;
  logic [31:0] cmd_data_in;
  logic [31:0] data_out = '0;
  logic        data_out_ready = 0;
  logic        busy, rd_timeout_err;

  int vectors = 0;
  int miscompares = 0;
  int ready_cnt;
  logic [3:0] rr_exp;

  sdram_cmd_arbiter #(.ADDR_W(23), .DATA_W(32), .RD_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
    .cmd_ready(cmd_ready), .cmd_enable(cmd_enable), .cmd_wr(cmd_wr),
    .cmd_address(cmd_address), .cmd_data_in(cmd_data_in),
    .data_out(data_out), .data_out_ready(data_out_ready),
    .busy(busy), .rd_timeout_err(rd_timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  // Called at the start of an IDLE cycle; returns at the start of the first WAIT_RD cycle.
  task automatic start_read(input logic port, input logic [22:0] addr);
    cmd_ready = 1'b1;
    if (port) begin req1_valid = 1; req1_wr = 0; req1_addr = addr; end
    else      begin req0_valid = 1; req0_wr = 0; req0_addr = addr; end
    to_pos();
    to_neg();
    chk("rd_accept_ready", {req1_ready, req0_ready}, port ? 2'b10 : 2'b01);
    chk("rd_cmd_addr", cmd_address, addr);
    to_pos();
    req0_valid = 0;
    req1_valid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    to_pos(); to_pos();
    to_neg();
    chk("rst_busy", busy, 0);
    chk("rst_cmd_enable", cmd_enable, 0);
    chk("rst_err", rd_timeout_err, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_cmd_address", cmd_address, 0);
    to_pos();
    rst = 0;

    // port 0 write, immediate accept
    req0_valid = 1; req0_wr = 1; req0_addr = 23'h000010; req0_data = 32'hDEADBEEF; cmd_ready = 1;
    to_neg();
    chk("wr_n_cmd_enable", cmd_enable, 0);
    to_pos();
    to_neg();
    chk("wr_n1_cmd_enable", cmd_enable, 1);
    chk("wr_n1_cmd_wr", cmd_wr, 1);
    chk("wr_n1_addr", cmd_address, 23'h000010);
    chk("wr_n1_data", cmd_data_in, 32'hDEADBEEF);
    chk("wr_n1_ready", {req1_ready, req0_ready}, 2'b01);
    to_pos();
    req0_valid = 0;
    to_neg();
    chk("wr_n2_cmd_enable", cmd_enable, 0);
    chk("wr_n2_busy", busy, 0);
    to_pos();

    // port 1 read, data 5 cycles after accept
    start_read(1'b1, 23'h000010);
    for (int i = 0; i < 4; i++) begin
      to_neg();
      chk("rd_wait_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
      to_pos();
    end
    data_out_ready = 1; data_out = 32'hDEADBEEF;
    to_neg();
    chk("rd_data_cycle_rsp", rsp1_valid, 0);
    to_pos();
    data_out_ready = 0;
    to_neg();
    chk("rd_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b10);
    chk("rd_rsp_data", rsp_data, 32'hDEADBEEF);
    chk("rd_done_busy", busy, 0);
    to_pos();
    to_neg();
    chk("rd_rsp_one_cycle", rsp1_valid, 0);

    // stray data_out_ready while idle
    to_pos();
    data_out_ready = 1; data_out = 32'h12345678;
    to_pos();
    data_out_ready = 0;
    to_neg();
    chk("stray_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
    chk("stray_rsp_data", rsp_data, 32'hDEADBEEF);
    to_pos();

    // both ports continuously requesting writes
`ifdef SDRAM_ARB_WR_PRIO_EN
    rr_exp = 4'b0000;
`else
    rr_exp = 4'b1010;
`endif
    req0_valid = 1; req0_wr = 1; req0_addr = 23'h000100; req0_data = 32'h00000100;
    req1_valid = 1; req1_wr = 1; req1_addr = 23'h000200; req1_data = 32'h00000200;
    cmd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      to_pos();
      to_neg();
      chk("rr_grant", {req1_ready, req0_ready}, rr_exp[i] ? 2'b10 : 2'b01);
      chk("rr_addr", cmd_address, rr_exp[i] ? 23'h000200 : 23'h000100);
      to_pos();
    end
    req0_valid = 0; req1_valid = 0;

    // controller stalls for 10 cycles
    req0_valid = 1; req0_wr = 1; req0_addr = 23'h000055; req0_data = 32'hA5A5A5A5;
    cmd_ready = 0;
    ready_cnt = 0;
    to_pos();
    for (int i = 0; i < 10; i++) begin
      to_neg();
      chk("stall_cmd_enable", cmd_enable, 1);
      chk("stall_addr", cmd_address, 23'h000055);
      chk("stall_data", cmd_data_in, 32'hA5A5A5A5);
      if (req0_ready || req1_ready) ready_cnt++;
      to_pos();
    end
    cmd_ready = 1;
    to_neg();
    if (req0_ready) ready_cnt++;
    chk("stall_ready_count", ready_cnt, 1);
    to_pos();
    req0_valid = 0;
    to_neg();
    chk("stall_done_enable", cmd_enable, 0);
    to_pos();

    // data on the terminal-count cycle wins over the timeout
    start_read(1'b0, 23'h000020);
    for (int i = 0; i < 7; i++) begin
      to_neg();
      chk("tc_wait_rsp", rsp0_valid, 0);
      to_pos();
    end
    data_out_ready = 1; data_out = 32'hCAFEF00D;
    to_pos();
    data_out_ready = 0;
    to_neg();
    chk("tc_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b01);
    chk("tc_rsp_data", rsp_data, 32'hCAFEF00D);
    chk("tc_no_err", rd_timeout_err, 0);
    to_pos();

    // read timeout
    start_read(1'b1, 23'h000077);
    for (int i = 0; i < 8; i++) begin
      to_neg();
      chk("to_wait_rsp", rsp1_valid, 0);
      chk("to_wait_err", rd_timeout_err, 0);
      to_pos();
    end
    to_neg();
    chk("to_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b10);
    chk("to_rsp_data", rsp_data, 0);
    chk("to_err", rd_timeout_err, 1);
    chk("to_busy", busy, 0);
    to_pos();
    to_neg();
    chk("to_err_sticky", rd_timeout_err, 1);
    chk("to_rsp_one_cycle", rsp1_valid, 0);
    to_pos();

    // reset during WAIT_RD, then late data
    start_read(1'b0, 23'h000099);
    to_pos();
    rst = 1;
    to_pos();
    rst = 0;
    data_out_ready = 1; data_out = 32'h11111111;
    to_neg();
    chk("rst_rd_busy", busy, 0);
    chk("rst_rd_enable", cmd_enable, 0);
    chk("rst_rd_err", rd_timeout_err, 0);
    chk("rst_rd_cmd_addr", cmd_address, 0);
    chk("rst_rd_cmd_wr", cmd_wr, 0);
    chk("rst_rd_rsp_data", rsp_data, 0);
    to_pos();
    data_out_ready = 0;
    to_neg();
    chk("rst_late_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
    chk("rst_late_rsp_data", rsp_data, 0);
    chk("rst_late_busy", busy, 0);
    to_pos();

    // after reset, a tie goes to port 0
    req0_valid = 1; req0_wr = 1; req0_addr = 23'h000001;
    req1_valid = 1; req1_wr = 1; req1_addr = 23'h000002;
    to_pos();
    to_neg();
    chk("rst_tie_grant", {req1_ready, req0_ready}, 2'b01);
    to_pos();
    req0_valid = 0; req1_valid = 0;
    to_pos();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
